// File: rtl/board_input_ctrl_pkg.sv
// Shared definitions for the board-input conditioning block.
//   - LED mux select encodings
//   - step single-step/auto-repeat FSM state encoding
//   - helper for the mode-button LED select cycler
package board_input_ctrl_pkg;

    // LED mux select values
    localparam logic [1:0] LED_SEL_INST_LO = 2'b00;   // inst[15:0]
    localparam logic [1:0] LED_SEL_INST_HI = 2'b01;   // inst[31:16]
    localparam logic [1:0] LED_SEL_CU      = 2'b10;   // control-unit concat

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DELAY  = 2'b01,
        S_REPEAT = 2'b10
    } step_state_t;

    // 00 -> 01 -> 10 -> 00; the unused code 11 also falls back to 00.
    function automatic logic [1:0] next_led_sel(input logic [1:0] cur);
        logic [1:0] nxt;
        case (cur)
            LED_SEL_INST_LO: nxt = LED_SEL_INST_HI;
            LED_SEL_INST_HI: nxt = LED_SEL_CU;
            default:         nxt = LED_SEL_INST_LO;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/board_input_ctrl_input_debouncer.sv
// Single-bit synchronizer plus debouncer.
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   raw   in  raw board input, asynchronous to clk
//   level out debounced level; changes only after the synchronized input has
//             differed from it for DEB_CYCLES consecutive cycles
// A clean raw edge appears on level DEB_CYCLES+2 clock edges later
// (two synchronizer stages, then DEB_CYCLES cycles of agreement).
module input_debouncer
    import board_input_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int unsigned     CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                // any return to the current level restarts the qualification
                cnt_q <= '0;
            end else if (cnt_q == CNT_TC) begin
                level <= sync_q2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_input_ctrl.sv
// Board-input conditioning for the FPGA debug display.
//   clk          in  system clock
//   rst          in  asynchronous active-low reset
//   btn_step_raw in  raw step pushbutton, active-high
//   btn_mode_raw in  raw mode pushbutton, active-high
//   sw_raw       in  raw slide switches
//   sw_db        out debounced switch levels
//   led_sel      out LED mux select, cycled by the mode button
//   step_pulse   out one-cycle step enable, with auto-repeat while held
//   mode_pulse   out one-cycle pulse per accepted mode press
//
// Step FSM states:
//   state    | meaning
//   S_IDLE   | button released, waiting for a press
//   S_DELAY  | first pulse issued, counting REPEAT_DELAY before auto-repeat
//   S_REPEAT | auto-repeat, one pulse every REPEAT_PERIOD cycles while held
module board_input_ctrl
    import board_input_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 100000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned SW_W          = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            btn_step_raw,
    input  logic            btn_mode_raw,
    input  logic [SW_W-1:0] sw_raw,
    output logic [SW_W-1:0] sw_db,
    output logic [1:0]      led_sel,
    output logic            step_pulse,
    output logic            mode_pulse
);

    localparam int unsigned     R_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned     R_W   = $clog2(R_MAX);
    localparam logic [R_W-1:0]  R_DELAY_TC  = R_W'(REPEAT_DELAY - 1);
    localparam logic [R_W-1:0]  R_PERIOD_TC = R_W'(REPEAT_PERIOD - 1);

    // A level already present at reset release reaches the debounced output
    // within this many edges; presses are only armed after that window.
    localparam int unsigned     SETTLE_CYCLES = DEB_CYCLES + 2;
    localparam int unsigned     SET_W         = $clog2(SETTLE_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_TC    = SET_W'(SETTLE_CYCLES - 1);

    logic d_step;
    logic d_mode;

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_step_raw),
        .level (d_step)
    );

    input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode_raw),
        .level (d_mode)
    );

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        input_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_raw[i]),
            .level (sw_db[i])
        );
    end

    // ------------------------------------------------------------------
    // Press detection with post-reset arming
    // ------------------------------------------------------------------
    logic             step_prev;
    logic             mode_prev;
    logic             step_armed;
    logic             mode_armed;
    logic             settled;
    logic [SET_W-1:0] settle_cnt;
    logic             step_press;
    logic             mode_press;

    // A button held through reset release only becomes armed once it has
    // been seen released, so it never produces a spurious press.
    assign step_press = d_step & ~step_prev & step_armed;
    assign mode_press = d_mode & ~mode_prev & mode_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_prev  <= 1'b0;
            mode_prev  <= 1'b0;
            step_armed <= 1'b0;
            mode_armed <= 1'b0;
            settled    <= 1'b0;
            settle_cnt <= '0;
        end else begin
            step_prev <= d_step;
            mode_prev <= d_mode;
            if (!settled) begin
                if (settle_cnt == SETTLE_TC) begin
                    settled <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
            if (settled && !d_step) begin
                step_armed <= 1'b1;
            end
            if (settled && !d_mode) begin
                mode_armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode: pulse and LED select cycler
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_pulse <= 1'b0;
            led_sel    <= LED_SEL_INST_LO;
        end else begin
            mode_pulse <= mode_press;
            if (mode_press) begin
                led_sel <= next_led_sel(led_sel);
            end
        end
    end

    // ------------------------------------------------------------------
    // Step FSM
    // ------------------------------------------------------------------
    step_state_t    state_q;
    step_state_t    state_d;
    logic [R_W-1:0] r_q;
    logic [R_W-1:0] r_d;
    logic           step_pulse_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            step_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            step_pulse <= step_pulse_d;
        end
    end

    // Release is tested before the terminal count so a button let go on the
    // terminal cycle never yields a final pulse.
    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        step_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (step_press) begin
                    step_pulse_d = 1'b1;
                    r_d          = '0;
                    state_d      = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!d_step) begin
                    state_d = S_IDLE;
                end else if (r_q == R_DELAY_TC) begin
                    step_pulse_d = 1'b1;
                    r_d          = '0;
                    state_d      = S_REPEAT;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            S_REPEAT: begin
                if (!d_step) begin
                    state_d = S_IDLE;
                end else if (r_q == R_PERIOD_TC) begin
                    step_pulse_d = 1'b1;
                    r_d          = '0;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                r_d     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_board_input_ctrl.sv
module tb_board_input_ctrl;

    localparam int DEB  = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int SW_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            btn_step_raw;
    logic            btn_mode_raw;
    logic [SW_W-1:0] sw_raw;
    logic [SW_W-1:0] sw_db;
    logic [1:0]      led_sel;
    logic            step_pulse;
    logic            mode_pulse;

    always #5 clk = ~clk;

    board_input_ctrl #(
        .DEB_CYCLES    (DEB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .SW_W          (SW_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_step_raw (btn_step_raw),
        .btn_mode_raw (btn_mode_raw),
        .sw_raw       (sw_raw),
        .sw_db        (sw_db),
        .led_sel      (led_sel),
        .step_pulse   (step_pulse),
        .mode_pulse   (mode_pulse)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: channel = raw seen two edges late, debounced once it
    // has disagreed with the held level for DEB consecutive edges.
    // ------------------------------------------------------------------
    typedef struct {
        bit ff1;
        bit s;
        bit d;
        bit dprev;
        int run;
    } chan_t;

    chan_t           m_ch [SW_W+2];
    bit              m_armed [2];
    bit              m_settled;
    int              m_edges;
    int              m_hold;      // edges since the press pulse, -1 when released
    int              m_presses;
    bit              exp_step;
    bit              exp_mode;
    logic [1:0]      exp_led;
    logic [SW_W-1:0] exp_sw;

    int cyc = 0;
    int pulse_cyc[$];
    int mode_seen;

    task automatic model_reset();
        for (int i = 0; i < SW_W + 2; i++) begin
            m_ch[i].ff1   = 1'b0;
            m_ch[i].s     = 1'b0;
            m_ch[i].d     = 1'b0;
            m_ch[i].dprev = 1'b0;
            m_ch[i].run   = 0;
        end
        m_armed[0] = 1'b0;
        m_armed[1] = 1'b0;
        m_settled  = 1'b0;
        m_edges    = 0;
        m_hold     = -1;
        m_presses  = 0;
        exp_step   = 1'b0;
        exp_mode   = 1'b0;
        exp_led    = 2'b00;
        exp_sw     = '0;
    endtask

    task automatic chan_edge(input int i, input bit raw);
        bit d_new;
        d_new = m_ch[i].d;
        if (m_ch[i].s != m_ch[i].d) begin
            m_ch[i].run++;
            if (m_ch[i].run == DEB) begin
                d_new       = m_ch[i].s;
                m_ch[i].run = 0;
            end
        end else begin
            m_ch[i].run = 0;
        end
        m_ch[i].dprev = m_ch[i].d;
        m_ch[i].d     = d_new;
        m_ch[i].s     = m_ch[i].ff1;
        m_ch[i].ff1   = raw;
    endtask

    task automatic model_edge();
        bit rise_step;
        bit rise_mode;
        rise_step = m_ch[0].d && !m_ch[0].dprev && m_armed[0];
        rise_mode = m_ch[1].d && !m_ch[1].dprev && m_armed[1];
        for (int b = 0; b < 2; b++)
            if (m_settled && !m_ch[b].d) m_armed[b] = 1'b1;
        m_edges++;
        m_settled = (m_edges >= DEB + 2);

        exp_step = 1'b0;
        if (m_hold >= 0) begin
            if (!m_ch[0].d) begin
                m_hold = -1;
            end else begin
                m_hold++;
                if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0))
                    exp_step = 1'b1;
            end
        end else if (rise_step) begin
            exp_step = 1'b1;
            m_hold   = 0;
        end

        exp_mode = rise_mode;
        if (rise_mode) m_presses++;
        exp_led = 2'(m_presses % 3);

        chan_edge(0, btn_step_raw);
        chan_edge(1, btn_mode_raw);
        for (int i = 0; i < SW_W; i++) chan_edge(2 + i, sw_raw[i]);
        for (int i = 0; i < SW_W; i++) exp_sw[i] = m_ch[2 + i].d;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check_val("step_pulse", {31'd0, step_pulse}, {31'd0, exp_step});
        check_val("mode_pulse", {31'd0, mode_pulse}, {31'd0, exp_mode});
        check_val("led_sel", {30'd0, led_sel}, {30'd0, exp_led});
        check_val("sw_db", {16'd0, sw_db}, {16'd0, exp_sw});
        if (step_pulse) pulse_cyc.push_back(cyc);
        if (mode_pulse) mode_seen++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn_step_raw = 1'b0;
        btn_mode_raw = 1'b0;
        sw_raw = '0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (12) tick();
    endtask

    int           c0;
    logic [1:0]   wrap_exp [4];
    int           srun;
    int           mrun;
    bit           found;

    initial begin
        model_reset();
        // Reset with step held: no pulse after release
        rst = 1'b0;
        btn_step_raw = 1'b1;
        btn_mode_raw = 1'b0;
        sw_raw = 16'(($urandom() & 32'hFFFF) | 32'h1);
        repeat (3) tick();
        rst = 1'b1;
        pulse_cyc.delete();
        repeat (30) tick();
        check_val("held_at_reset_no_step", pulse_cyc.size(), 0);
        btn_step_raw = 1'b0;
        sw_raw = '0;
        repeat (15) tick();

        // Bouncing mode button, then a clean hold
        mode_seen = 0;
        for (int i = 0; i < 20; i++) begin
            btn_mode_raw = ((i / 2) % 2 == 0);
            tick();
        end
        check_val("bounce_no_mode", mode_seen, 0);
        btn_mode_raw = 1'b1;
        repeat (12) tick();
        check_val("bounce_then_hold_mode", mode_seen, 1);
        check_val("bounce_led_sel", {30'd0, led_sel}, 32'd1);
        btn_mode_raw = 1'b0;
        repeat (10) tick();

        // Mode wrap from reset
        do_reset();
        wrap_exp[0] = 2'b01; wrap_exp[1] = 2'b10; wrap_exp[2] = 2'b00; wrap_exp[3] = 2'b01;
        for (int p = 0; p < 4; p++) begin
            btn_mode_raw = 1'b1;
            repeat (8) tick();
            btn_mode_raw = 1'b0;
            repeat (8) tick();
            check_val("mode_wrap", {30'd0, led_sel}, {30'd0, wrap_exp[p]});
        end

        // Auto-repeat: held 40 cycles past debounce
        pulse_cyc.delete();
        c0 = cyc;
        btn_step_raw = 1'b1;
        repeat (46) tick();
        btn_step_raw = 1'b0;
        repeat (20) tick();
        check_val("repeat_count", pulse_cyc.size(), 13);
        if (pulse_cyc.size() >= 3) begin
            check_val("repeat_first", pulse_cyc[0] - c0, 7);
            check_val("repeat_delay", pulse_cyc[1] - pulse_cyc[0], RD);
            check_val("repeat_period", pulse_cyc[2] - pulse_cyc[1], RP);
        end

        // Release landing on the repeat terminal count
        pulse_cyc.delete();
        btn_step_raw = 1'b1;
        repeat (13) tick();
        btn_step_raw = 1'b0;
        repeat (20) tick();
        check_val("tc_release_count", pulse_cyc.size(), 2);
        pulse_cyc.delete();
        c0 = cyc;
        btn_step_raw = 1'b1;
        repeat (8) tick();
        btn_step_raw = 1'b0;
        repeat (12) tick();
        check_val("idle_after_tc_count", pulse_cyc.size(), 1);
        if (pulse_cyc.size() >= 1) check_val("idle_after_tc_first", pulse_cyc[0] - c0, 7);

        // Switch debounce and glitch rejection
        sw_raw = 16'hA5C3;
        repeat (5) tick();
        check_val("sw_not_yet", {16'd0, sw_db}, 32'h0);
        tick();
        check_val("sw_settled", {16'd0, sw_db}, 32'hA5C3);
        sw_raw = 16'hA5C2;
        tick();
        sw_raw = 16'hA5C3;
        repeat (10) tick();
        check_val("sw_glitch", {16'd0, sw_db}, 32'hA5C3);

        // Randomized mix
        srun = 0;
        mrun = 0;
        for (int i = 0; i < 2500; i++) begin
            if (srun == 0) begin
                btn_step_raw = $urandom_range(0, 1) != 0;
                srun = $urandom_range(1, 45);
            end
            if (mrun == 0) begin
                btn_mode_raw = $urandom_range(0, 1) != 0;
                mrun = $urandom_range(1, 12);
            end
            srun--;
            mrun--;
            if ($urandom_range(0, 5) == 0) sw_raw[$urandom_range(0, SW_W - 1)] ^= 1'b1;
            tick();
        end

        // Reset asserted while a repeat pulse is on the output
        btn_step_raw = 1'b0;
        btn_mode_raw = 1'b0;
        sw_raw = 16'h3C5A;
        repeat (20) tick();
        btn_step_raw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (exp_step && m_hold > RD) found = 1'b1;
        end
        check_val("repeat_found", {31'd0, found}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
        check_val("rst_sw_db", {16'd0, sw_db}, 32'd0);
        check_val("rst_led_sel", {30'd0, led_sel}, 32'd0);
        model_reset();
        btn_step_raw = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (12) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
